// File: rtl/exe_md_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exe_md_ctrl_pkg : shared constants and types for the RV32M         |
// | multiply/divide sequencer.                                          |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package exe_md_ctrl_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int RADDR_WIDTH = 5;
  localparam int DIV_ITER    = DATA_WIDTH;

  localparam logic [6:0] INST_M_F = 7'b0000001;

  localparam logic [2:0] INST_MUL    = 3'b000;
  localparam logic [2:0] INST_MULH   = 3'b001;
  localparam logic [2:0] INST_MULHSU = 3'b010;
  localparam logic [2:0] INST_MULHU  = 3'b011;
  localparam logic [2:0] INST_DIV    = 3'b100;
  localparam logic [2:0] INST_DIVU   = 3'b101;
  localparam logic [2:0] INST_REM    = 3'b110;
  localparam logic [2:0] INST_REMU   = 3'b111;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = MD_IDLE,
    ST_CALC = MD_CALC,
    ST_DONE = MD_DONE
  } md_state_e;

  function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                     input logic neg);
    return neg ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exe_md_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exe_md_ctrl_if : exe-stage <-> M-extension sequencer bundle.        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
interface exe_md_ctrl_if;
  import exe_md_ctrl_pkg::*;

  logic                   start_i;
  logic [2:0]             op_i;
  logic [DATA_WIDTH-1:0]  op1_i;
  logic [DATA_WIDTH-1:0]  op2_i;
  logic [RADDR_WIDTH-1:0] reg_waddr_i;
  logic                   flush_i;
  logic                   stallreq_o;
  logic                   busy_o;
  logic                   result_valid_o;
  logic [DATA_WIDTH-1:0]  result_o;
  logic [RADDR_WIDTH-1:0] reg_waddr_o;
  logic                   reg_we_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    input  stallreq_o, busy_o, result_valid_o, result_o, reg_waddr_o, reg_we_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, reg_waddr_i, flush_i,
    output stallreq_o, busy_o, result_valid_o, result_o, reg_waddr_o, reg_we_o
  );
endinterface
`default_nettype wire

// File: rtl/exe_md_ctrl_div.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | md_div_core : unsigned restoring divider, one quotient bit/cycle.   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module md_div_core
  import exe_md_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  wire logic             clk_i,
  input  wire logic             rst_n_i,
  input  wire logic             start,
  input  wire logic [WIDTH-1:0] dividend,
  input  wire logic [WIDTH-1:0] divisor,
  output logic                  done,
  output logic [WIDTH-1:0]      quotient,
  output logic [WIDTH-1:0]      remainder
);

  localparam int c_cnt_w = $clog2(WIDTH);

  logic               r_busy;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH:0]     w_part;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;

  // quotient/remainder are the post-step values, so they are final while done is high
  assign w_part    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_part - {1'b0, r_dvs};
  assign w_qbit    = ~w_diff[WIDTH];
  assign quotient  = {r_quo[WIDTH-2:0], w_qbit};
  assign remainder = w_qbit ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];
  assign done      = r_busy && (r_cnt == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= c_cnt_w'(WIDTH - 1);
      r_quo  <= dividend;
      r_rem  <= '0;
      r_dvs  <= divisor;
    end else if (r_busy) begin
      r_quo <= quotient;
      r_rem <= remainder;
      r_cnt <= r_cnt - c_cnt_w'(1);
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/exe_md_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exe_md_ctrl : RV32M sequencer - single-pass multiply, iterative     |
// | divide, pipeline stall and flush handling. Revision: 1.0            |
// +--------------------------------------------------------------------+
module exe_md_ctrl
  import exe_md_ctrl_pkg::*;
(
  input  wire logic     clk_i,
  input  wire logic     rst_n_i,
  exe_md_ctrl_if.slave  md
);

  md_state_e              r_state, w_state_nxt;
  logic [2:0]             r_op;
  logic [DATA_WIDTH-1:0]  r_op1, r_op2;
  logic [RADDR_WIDTH-1:0] r_rd;
  logic                   r_neg_q, r_neg_r;
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_result;
  logic [RADDR_WIDTH-1:0] r_waddr;

  logic                   w_accept, w_is_div, w_sdiv, w_div0, w_ovf, w_special;
  logic                   w_div_start, w_div_done;
  logic [DATA_WIDTH-1:0]  w_mag1, w_mag2, w_quo, w_rem;
  logic [63:0]            w_ext1, w_ext2, w_prod;
  logic                   w_load;
  logic [DATA_WIDTH-1:0]  w_res_nxt;
  logic [RADDR_WIDTH-1:0] w_rd_nxt;

  assign w_accept    = (r_state == ST_IDLE) && md.start_i && !md.flush_i;
  assign w_is_div    = md.op_i[2];
  assign w_sdiv      = !md.op_i[0];
  assign w_div0      = (md.op2_i == '0);
  assign w_ovf       = w_sdiv && (md.op1_i == 32'h8000_0000) && (md.op2_i == '1);
  assign w_special   = w_is_div && (w_div0 || w_ovf);
  assign w_div_start = w_accept && w_is_div && !w_special;
  assign w_mag1      = cond_neg(md.op1_i, w_sdiv && md.op1_i[31]);
  assign w_mag2      = cond_neg(md.op2_i, w_sdiv && md.op2_i[31]);

  md_div_core #(.WIDTH(DATA_WIDTH)) u_div (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .start     (w_div_start),
    .dividend  (w_mag1),
    .divisor   (w_mag2),
    .done      (w_div_done),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // 64-bit sign extension keeps the low 64 product bits exact for every signedness mix
  assign w_ext1 = {{32{(r_op[1:0] != 2'b11) && r_op1[31]}}, r_op1};
  assign w_ext2 = {{32{(r_op[1:0] == 2'b01) && r_op2[31]}}, r_op2};
  assign w_prod = w_ext1 * w_ext2;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_res_nxt   = r_result;
    w_rd_nxt    = r_rd;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_special) begin
            w_state_nxt = ST_DONE;
            w_load      = 1'b1;
            w_rd_nxt    = md.reg_waddr_i;
            if (w_div0) w_res_nxt = md.op_i[1] ? md.op1_i : '1;
            else        w_res_nxt = md.op_i[1] ? '0 : 32'h8000_0000;
          end else begin
            w_state_nxt = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (!r_op[2]) begin
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
          w_res_nxt   = (r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
        end else if (w_div_done) begin
          w_state_nxt = ST_DONE;
          w_load      = 1'b1;
          w_res_nxt   = r_op[1] ? cond_neg(w_rem, r_neg_r) : cond_neg(w_quo, r_neg_q);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (md.flush_i) begin
      w_state_nxt = ST_IDLE;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_rd     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_waddr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_load;
      if (w_accept) begin
        r_op    <= md.op_i;
        r_op1   <= md.op1_i;
        r_op2   <= md.op2_i;
        r_rd    <= md.reg_waddr_i;
        r_neg_q <= w_sdiv && (md.op1_i[31] ^ md.op2_i[31]);
        r_neg_r <= w_sdiv && md.op1_i[31];
      end
      if (w_load) begin
        r_result <= w_res_nxt;
        r_waddr  <= w_rd_nxt;
      end
    end
  end

  assign md.stallreq_o     = rst_n_i && !md.flush_i &&
                             (((r_state == ST_IDLE) && md.start_i) || (r_state == ST_CALC));
  assign md.busy_o         = (r_state != ST_IDLE);
  assign md.result_valid_o = r_valid;
  assign md.reg_we_o       = r_valid;
  assign md.result_o       = r_result;
  assign md.reg_waddr_o    = r_waddr;

endmodule
`default_nettype wire

// File: tb/tb_exe_md_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_exe_md_ctrl : directed self-checking bench for exe_md_ctrl.      |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_exe_md_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exe_md_ctrl_if mif();

  exe_md_ctrl u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .md      (mif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op at the current (post-edge) time and measure latency/stalls
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int lat);
    int t;
    int stalls;
    mif.start_i     = 1'b1;
    mif.op_i        = op;
    mif.op1_i       = a;
    mif.op2_i       = b;
    mif.reg_waddr_i = rd;
    stalls = 0;
    for (t = 0; t <= 40; t++) begin
      @(negedge clk);
      if (mif.result_valid_o) break;
      if (mif.stallreq_o) stalls++;
      @(posedge clk);
      #1;
    end
    check({tag, " latency"}, t, lat);
    check({tag, " stalls"}, stalls, lat);
    check({tag, " result"}, mif.result_o, exp);
    check({tag, " waddr"}, {27'd0, mif.reg_waddr_o}, {27'd0, rd});
    check({tag, " we"}, {31'd0, mif.reg_we_o}, 32'd1);
    check({tag, " stall_done"}, {31'd0, mif.stallreq_o}, 32'd0);
    @(posedge clk);
    #1;
    mif.start_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " stall"}, {31'd0, mif.stallreq_o}, 32'd0);
    check({tag, " busy"}, {31'd0, mif.busy_o}, 32'd0);
    check({tag, " valid"}, {31'd0, mif.result_valid_o}, 32'd0);
    check({tag, " we"}, {31'd0, mif.reg_we_o}, 32'd0);
    check({tag, " result"}, mif.result_o, 32'd0);
    check({tag, " waddr"}, {27'd0, mif.reg_waddr_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int vcnt;
    checks = 0;
    errors = 0;
    rst_n           = 1'b0;
    mif.start_i     = 1'b1;
    mif.op_i        = 3'b000;
    mif.op1_i       = 32'd1;
    mif.op2_i       = 32'd1;
    mif.reg_waddr_i = 5'd1;
    mif.flush_i     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk);
    #1;
    mif.start_i = 1'b0;
    rst_n       = 1'b1;
    @(posedge clk);
    #1;

    // Multiply family
    run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 2);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 2);
    run_op("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 2);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 2);

    // Unsigned and signed divide
    run_op("divu",   3'b101, 32'd100,      32'd7,         5'd9,  32'd14,        33);
    run_op("remu",   3'b111, 32'd100,      32'd7,         5'd10, 32'd2,         33);
    run_op("div_n",  3'b100, 32'hFFFF_FFF9, 32'd2,        5'd11, 32'hFFFF_FFFD, 33);
    run_op("rem_n",  3'b110, 32'hFFFF_FFF9, 32'd2,        5'd12, 32'hFFFF_FFFF, 33);
    run_op("div_d",  3'b100, 32'd7,        32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 33);
    run_op("rem_d",  3'b110, 32'd7,        32'hFFFF_FFFE, 5'd14, 32'd1,         33);

    // Special cases resolved without iterating
    run_op("div0",   3'b100, 32'd5,        32'd0,         5'd15, 32'hFFFF_FFFF, 1);
    run_op("rem0",   3'b110, 32'd5,        32'd0,         5'd16, 32'd5,         1);
    run_op("divu0",  3'b101, 32'd5,        32'd0,         5'd17, 32'hFFFF_FFFF, 1);
    run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
    run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         1);

    // Flush at T10 of a DIVU
    mif.start_i     = 1'b1;
    mif.op_i        = 3'b101;
    mif.op1_i       = 32'd1000;
    mif.op2_i       = 32'd3;
    mif.reg_waddr_i = 5'd20;
    repeat (10) @(posedge clk);
    #1;
    mif.flush_i = 1'b1;
    mif.start_i = 1'b0;
    @(negedge clk);
    check("flush stall", {31'd0, mif.stallreq_o}, 32'd0);
    @(posedge clk);
    #1;
    mif.flush_i = 1'b0;
    @(negedge clk);
    check("flush idle", {31'd0, mif.busy_o}, 32'd0);
    vcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mif.result_valid_o) vcnt++;
    end
    check("flush no_valid", vcnt, 0);
    @(posedge clk);
    #1;
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 2);

    // Asynchronous reset in the middle of a DIV
    mif.start_i     = 1'b1;
    mif.op_i        = 3'b100;
    mif.op1_i       = 32'd77;
    mif.op2_i       = 32'd5;
    mif.reg_waddr_i = 5'd22;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    mif.start_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset busy", {31'd0, mif.busy_o}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: the MUL is issued in the IDLE cycle right after DONE
    run_op("b2b_divu", 3'b101, 32'd100,    32'd7, 5'd23, 32'd14,   33);
    run_op("b2b_mul",  3'b000, 32'd1234,   32'd5, 5'd24, 32'd6170, 2);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
